twi_slave: RTL and testbench



---
 rtl/twi_slave.sv | 195 +++++++++++++++++++
 tb/tb_twi_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/twi_slave.sv
// I2C target: oversampled/filtered SCL+SDA, 7-bit address match, and an 8-bit
// register-pointer interface with auto-incrementing writes and sequential reads.
module twi_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 3
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       TWI_SCL_I,
  input  logic       TWI_SDA_I,
  output logic       TWI_SDA_OEN,
  output logic [7:0] REG_ADDR,
  output logic       REG_WR,
  output logic [7:0] REG_WDAT,
  output logic       REG_RD,
  input  logic [7:0] REG_RDAT,
  output logic       BUSY
);

  localparam int             CW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0]  FMAX = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0]  FONE = CW'(1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  // Stage p0/p1: two-flop synchronizer, then a counter glitch filter per line
  // (bit 1 = SCL, bit 0 = SDA). Filtered level changes only after FILT_LEN
  // consecutive samples disagree with it.
  logic [1:0]    sync_p0, sync_p1, filt, filt_d;
  logic [CW-1:0] fcnt [2];

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync_p0 <= {TWI_SCL_I, TWI_SDA_I};
      sync_p1 <= sync_p0;
      filt_d  <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FMAX) begin
          filt[i] <= sync_p1[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FONE;
        end
      end
    end
  end

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;
  logic [7:0] shreg;
  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic       rw, match;

  assign scl_rise = filt[1] & ~filt_d[1];
  assign scl_fall = ~filt[1] & filt_d[1];
  assign start_c  = filt[1] & filt_d[1] & filt_d[0] & ~filt[0];
  assign stop_c   = filt[1] & filt_d[1] & ~filt_d[0] & filt[0];
  assign byte_in  = {shreg[6:0], filt[0]};

  // Stage p2: protocol FSM driven by filtered edges
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      rw          <= 1'b0;
      match       <= 1'b0;
      TWI_SDA_OEN <= 1'b1;
      BUSY        <= 1'b0;
      REG_WR      <= 1'b0;
      REG_RD      <= 1'b0;
      REG_ADDR    <= 8'd0;
      REG_WDAT    <= 8'd0;
    end else begin
      REG_WR <= 1'b0;
      REG_RD <= 1'b0;
      if (REG_WR) REG_ADDR <= REG_ADDR + 8'd1;

      if (start_c) begin
        state       <= S_ADDR;
        bit_cnt     <= 4'd0;
        TWI_SDA_OEN <= 1'b1;
        BUSY        <= 1'b1;
      end else if (stop_c) begin
        state       <= S_IDLE;
        TWI_SDA_OEN <= 1'b1;
        BUSY        <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rw    <= filt[0];
                match <= (shreg[6:0] == SLAVE_ADDR) && (shreg[6:0] != 7'd0);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (match) begin
                state       <= S_ADDR_ACK;
                TWI_SDA_OEN <= 1'b0;
              end else begin
                state <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                state       <= S_RDATA;
                shreg       <= REG_RDAT;
                REG_RD      <= 1'b1;
                TWI_SDA_OEN <= REG_RDAT[7];
              end else begin
                state       <= S_PTR;
                TWI_SDA_OEN <= 1'b1;
              end
            end
          end
          S_PTR, S_WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == S_PTR) begin
                  REG_ADDR <= byte_in;
                end else begin
                  REG_WDAT <= byte_in;
                  REG_WR   <= 1'b1;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state       <= (state == S_PTR) ? S_PTR_ACK : S_WDATA_ACK;
              TWI_SDA_OEN <= 1'b0;
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              state       <= S_WDATA;
              bit_cnt     <= 4'd0;
              TWI_SDA_OEN <= 1'b1;
            end
          end
          S_RDATA: begin
            // Bit 7 went out at entry; seven more falls present bits 6..0,
            // the eighth releases SDA for the master's ACK.
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                state       <= S_RDATA_ACK;
                TWI_SDA_OEN <= 1'b1;
              end else begin
                shreg       <= {shreg[6:0], 1'b0};
                TWI_SDA_OEN <= shreg[6];
                bit_cnt     <= bit_cnt + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!filt[0]) REG_ADDR <= REG_ADDR + 8'd1;
              else          state    <= S_WAIT_STOP;
            end else if (scl_fall) begin
              state       <= S_RDATA;
              bit_cnt     <= 4'd0;
              shreg       <= REG_RDAT;
              REG_RD      <= 1'b1;
              TWI_SDA_OEN <= REG_RDAT[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_twi_slave.sv
// Directed bench for twi_slave: a bit-banged bus master drives write, read,
// address-miss, pointer-wrap, glitch and mid-ACK reset sequences.
module tb_twi_slave;

  localparam int FILT_LEN = 3;
  localparam int Q        = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oen;
  logic       sda_bus;
  logic [7:0] reg_addr, reg_wdat, reg_rdat;
  logic       reg_wr, reg_rd, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  logic [15:0] wq[$];

  assign sda_bus  = sda_m & sda_oen;
  assign reg_rdat = ~reg_addr;

  twi_slave #(.SLAVE_ADDR(7'h50), .FILT_LEN(FILT_LEN)) dut (
    .CLK_I(clk), .RST_I(rst), .TWI_SCL_I(scl_m), .TWI_SDA_I(sda_bus),
    .TWI_SDA_OEN(sda_oen), .REG_ADDR(reg_addr), .REG_WR(reg_wr),
    .REG_WDAT(reg_wdat), .REG_RD(reg_rd), .REG_RDAT(reg_rdat), .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) wq.push_back({reg_addr, reg_wdat});
    if (reg_rd) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wq_at(input int i);
    return (i < wq.size()) ? wq[i] : 16'hxxxx;
  endfunction

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic r);
    sda_m = b; q_wait();
    if (glitch) begin
      scl_m = 1'b1;
      repeat (FILT_LEN - 1) @(negedge clk);
      scl_m = 1'b0;
      q_wait();
    end
    scl_m = 1'b1; q_wait();
    r = sda_bus;  q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], (7 - i) == glitch_bit, r);
    clk_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, r);
      d = {d[6:0], r};
    end
    clk_bit(nack, 1'b0, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         wbase, rbase;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oen", sda_oen, 1);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wr", reg_wr, 0);
    chk("rst_rd", reg_rd, 0);
    chk("rst_wdat", reg_wdat, 8'h00);
    chk("rst_busy", busy, 0);

    // Write with a short SCL glitch inside the pointer byte
    wbase = wq.size();
    bus_start();
    chk("wr_busy", busy, 1);
    write_byte(8'hA0, -1, ack); chk("wr_ack_addr", ack, 0);
    write_byte(8'h10, 3, ack);  chk("wr_ack_ptr", ack, 0);
    write_byte(8'h5A, -1, ack); chk("wr_ack_d0", ack, 0);
    write_byte(8'hC3, -1, ack); chk("wr_ack_d1", ack, 0);
    bus_stop();
    q_wait();
    chk("wr_busy_end", busy, 0);
    chk("wr_count", wq.size() - wbase, 2);
    chk("wr_0", wq_at(wbase), 16'h105A);
    chk("wr_1", wq_at(wbase + 1), 16'h11C3);
    chk("wr_addr", reg_addr, 8'h12);

    // Pointer write, repeated START, sequential read
    rbase = rd_cnt;
    bus_start();
    write_byte(8'hA0, -1, ack); chk("rd_ack_addr", ack, 0);
    write_byte(8'h20, -1, ack); chk("rd_ack_ptr", ack, 0);
    bus_start();
    write_byte(8'hA1, -1, ack); chk("rd_ack_raddr", ack, 0);
    read_byte(1'b0, d); chk("rd_byte0", d, 8'hDF);
    read_byte(1'b1, d); chk("rd_byte1", d, 8'hDE);
    chk("rd_released", sda_oen, 1);
    bus_stop();
    q_wait();
    chk("rd_pulses", rd_cnt - rbase, 2);
    chk("rd_addr", reg_addr, 8'h21);
    chk("rd_busy_end", busy, 0);

    // Address miss
    wbase = wq.size();
    bus_start();
    write_byte(8'hA2, -1, ack); chk("miss_ack_addr", ack, 1);
    write_byte(8'h55, -1, ack); chk("miss_ack_data", ack, 1);
    bus_stop();
    q_wait();
    chk("miss_nowr", wq.size() - wbase, 0);
    chk("miss_addr", reg_addr, 8'h21);

    // Pointer wrap 0xFF -> 0x00
    wbase = wq.size();
    bus_start();
    write_byte(8'hA0, -1, ack); chk("wrap_ack_addr", ack, 0);
    write_byte(8'hFF, -1, ack); chk("wrap_ack_ptr", ack, 0);
    write_byte(8'h11, -1, ack); chk("wrap_ack_d0", ack, 0);
    write_byte(8'h22, -1, ack); chk("wrap_ack_d1", ack, 0);
    bus_stop();
    q_wait();
    chk("wrap_count", wq.size() - wbase, 2);
    chk("wrap_0", wq_at(wbase), 16'hFF11);
    chk("wrap_1", wq_at(wbase + 1), 16'h0022);
    chk("wrap_addr", reg_addr, 8'h01);

    // Reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0, r);
    sda_m = 1'b1;
    chk("rstack_driving", sda_oen, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstack_oen", sda_oen, 1);
    chk("rstack_wr", reg_wr, 0);
    chk("rstack_rd", reg_rd, 0);
    chk("rstack_busy", busy, 0);
    chk("rstack_addr", reg_addr, 8'h00);
    rst = 1'b0;
    q_wait();
    bus_stop();
    q_wait();

    wbase = wq.size();
    bus_start();
    write_byte(8'hA0, -1, ack); chk("post_ack_addr", ack, 0);
    write_byte(8'h30, -1, ack); chk("post_ack_ptr", ack, 0);
    write_byte(8'h77, -1, ack); chk("post_ack_d0", ack, 0);
    bus_stop();
    q_wait();
    chk("post_count", wq.size() - wbase, 1);
    chk("post_wr", wq_at(wbase), 16'h3077);
    chk("post_addr", reg_addr, 8'h31);
    chk("post_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
